// File: rtl/rst_req_ctrl.sv
// rst_req_ctrl: turns software/watchdog requests into a stretched reset
// request, then follows the generator's ready drop/return before re-arming.
module rst_req_ctrl #(
    parameter int                   WDT_WIDTH    = 24,
    parameter logic [WDT_WIDTH-1:0] WDT_LIMIT    = 24'd10_000_000,
    parameter int                   RST_PULSE    = 16,
    parameter int                   DROP_TIMEOUT = 255
) (
    input  logic       pll_clk,
    input  logic       i_brd_rst,
    input  logic       i_sys_ready,
    input  logic       i_wdt_en,
    input  logic       i_wdt_kick,
    input  logic       i_soft_req,
    output logic       o_rst_req,
    output logic [1:0] o_rst_cause,
    output logic       o_drop_err,
    output logic       o_busy
);

    localparam logic [1:0] ST_WAIT_READY = 2'd0;
    localparam logic [1:0] ST_ARMED      = 2'd1;
    localparam logic [1:0] ST_ASSERT     = 2'd2;
    localparam logic [1:0] ST_WAIT_DROP  = 2'd3;

    localparam logic [WDT_WIDTH-1:0] WDT_LAST  = WDT_LIMIT - WDT_WIDTH'(1);
    localparam logic [7:0]           PULSE_LD  = 8'(RST_PULSE);
    localparam logic [7:0]           DROP_LAST = 8'(DROP_TIMEOUT - 1);

    logic [1:0]           state_q, state_d;
    logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
    logic [7:0]           pulse_cnt_q, pulse_cnt_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 drop_seen_q, drop_seen_d;
    logic                 rst_req_q, rst_req_d;
    logic [1:0]           cause_q, cause_d;
    logic                 drop_err_q, drop_err_d;
    logic [1:0]           en_sync_q, en_sync_d;
    logic [2:0]           kick_sync_q, kick_sync_d;
    logic [2:0]           soft_sync_q, soft_sync_d;

    logic wdt_en;
    logic kick_ev;
    logic soft_ev;
    logic wdt_expire;

    always_comb begin
        en_sync_d   = {en_sync_q[0], i_wdt_en};
        kick_sync_d = {kick_sync_q[1:0], i_wdt_kick};
        soft_sync_d = {soft_sync_q[1:0], i_soft_req};

        wdt_en     = en_sync_q[1];
        kick_ev    = kick_sync_q[1] & ~kick_sync_q[2];
        soft_ev    = soft_sync_q[1] & ~soft_sync_q[2];
        wdt_expire = wdt_en & ~kick_ev & (wdt_cnt_q == WDT_LAST);
    end

    always_comb begin
        state_d     = state_q;
        wdt_cnt_d   = '0;
        pulse_cnt_d = pulse_cnt_q;
        drop_cnt_d  = '0;
        drop_seen_d = drop_seen_q;
        rst_req_d   = 1'b0;
        cause_d     = cause_q;
        drop_err_d  = drop_err_q;

        unique case (state_q)
            ST_WAIT_READY: begin
                if (i_sys_ready) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // An external reset already in flight outranks any request.
                if (!i_sys_ready) begin
                    state_d = ST_WAIT_READY;
                end else if (soft_ev || wdt_expire) begin
                    state_d     = ST_ASSERT;
                    cause_d     = soft_ev ? 2'b01 : 2'b10;
                    pulse_cnt_d = PULSE_LD;
                    drop_seen_d = 1'b0;
                end else if (wdt_en && !kick_ev) begin
                    wdt_cnt_d = wdt_cnt_q + WDT_WIDTH'(1);
                end
            end
            ST_ASSERT: begin
                drop_seen_d = drop_seen_q | ~i_sys_ready;
                if (pulse_cnt_q != 8'd0) begin
                    rst_req_d   = 1'b1;
                    pulse_cnt_d = pulse_cnt_q - 8'd1;
                end else begin
                    state_d = ST_WAIT_DROP;
                end
            end
            ST_WAIT_DROP: begin
                if (drop_seen_q || !i_sys_ready) begin
                    state_d = ST_WAIT_READY;
                end else if (drop_cnt_q == DROP_LAST) begin
                    drop_err_d = 1'b1;
                    state_d    = ST_WAIT_READY;
                end else begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_WAIT_READY;
            end
        endcase
    end

    always_ff @(posedge pll_clk or posedge i_brd_rst) begin
        if (i_brd_rst) begin
            state_q     <= ST_WAIT_READY;
            wdt_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            drop_cnt_q  <= '0;
            drop_seen_q <= 1'b0;
            rst_req_q   <= 1'b0;
            cause_q     <= 2'b00;
            drop_err_q  <= 1'b0;
            en_sync_q   <= '0;
            kick_sync_q <= '0;
            soft_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            wdt_cnt_q   <= wdt_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_seen_q <= drop_seen_d;
            rst_req_q   <= rst_req_d;
            cause_q     <= cause_d;
            drop_err_q  <= drop_err_d;
            en_sync_q   <= en_sync_d;
            kick_sync_q <= kick_sync_d;
            soft_sync_q <= soft_sync_d;
        end
    end

    assign o_rst_req   = rst_req_q;
    assign o_rst_cause = cause_q;
    assign o_drop_err  = drop_err_q;
    assign o_busy      = (state_q != ST_ARMED);

endmodule

// File: tb/tb_rst_req_ctrl.sv
// tb_rst_req_ctrl: directed scenarios plus random stimulus, checked every
// cycle against a cycle-count based behavioural model.
module tb_rst_req_ctrl;

    localparam int P  = 16;
    localparam int DT = 255;
    localparam int WL = 100;

    logic       pll_clk     = 1'b0;
    logic       i_brd_rst   = 1'b0;
    logic       i_sys_ready = 1'b0;
    logic       i_wdt_en    = 1'b0;
    logic       i_wdt_kick  = 1'b0;
    logic       i_soft_req  = 1'b0;
    logic       o_rst_req;
    logic [1:0] o_rst_cause;
    logic       o_drop_err;
    logic       o_busy;

    int  total  = 0;
    int  bad    = 0;
    int  cyc    = 0;
    bit  cmp_on = 1'b0;

    rst_req_ctrl #(
        .WDT_WIDTH   (24),
        .WDT_LIMIT   (24'd100),
        .RST_PULSE   (P),
        .DROP_TIMEOUT(DT)
    ) dut (
        .pll_clk    (pll_clk),
        .i_brd_rst  (i_brd_rst),
        .i_sys_ready(i_sys_ready),
        .i_wdt_en   (i_wdt_en),
        .i_wdt_kick (i_wdt_kick),
        .i_soft_req (i_soft_req),
        .o_rst_req  (o_rst_req),
        .o_rst_cause(o_rst_cause),
        .o_drop_err (o_drop_err),
        .o_busy     (o_busy)
    );

    always #5 pll_clk = ~pll_clk;
    always @(posedge pll_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s: got %0d want %0d (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pll_clk);
        #1;
    endtask

    // Model: modes 0 wait-ready, 1 armed, 2 pulsing, 3 wait-drop.
    // Pulse and drop timing are derived from the cycle number of entry.
    int       m_mode, m_run, m_pstart, m_wstart, m_cyc;
    bit       m_req, m_err, m_busy, m_seen;
    bit [1:0] m_cause;
    bit [2:0] kh, sh;
    bit [1:0] eh;

    initial begin
        m_mode = 0; m_run = 0; m_pstart = 0; m_wstart = 0; m_cyc = 0;
        m_req = 0; m_err = 0; m_busy = 1; m_seen = 0; m_cause = 0;
        kh = 0; sh = 0; eh = 0;
        forever begin
            @(posedge pll_clk or posedge i_brd_rst);
            if (i_brd_rst) begin
                m_mode = 0; m_run = 0; m_req = 0; m_err = 0;
                m_busy = 1; m_seen = 0; m_cause = 0;
                kh = 0; sh = 0; eh = 0;
            end else begin : step
                bit kev, sev, en, expire;
                m_cyc++;
                kev = kh[1] & ~kh[2];
                sev = sh[1] & ~sh[2];
                en  = eh[1];
                kh  = {kh[1:0], i_wdt_kick};
                sh  = {sh[1:0], i_soft_req};
                eh  = {eh[0], i_wdt_en};
                case (m_mode)
                    0: begin
                        m_run = 0;
                        if (i_sys_ready) m_mode = 1;
                    end
                    1: begin
                        expire = en && !kev && (m_run == WL - 1);
                        if (!i_sys_ready) begin
                            m_mode = 0; m_run = 0;
                        end else if (sev || expire) begin
                            m_mode = 2; m_cause = sev ? 2'b01 : 2'b10;
                            m_pstart = m_cyc; m_seen = 0; m_run = 0;
                        end else begin
                            m_run = (en && !kev) ? m_run + 1 : 0;
                        end
                    end
                    2: begin
                        if (!i_sys_ready) m_seen = 1;
                        if (m_cyc == m_pstart + P + 1) begin
                            m_mode = 3; m_wstart = m_cyc;
                        end
                    end
                    default: begin
                        if (m_seen || !i_sys_ready) m_mode = 0;
                        else if (m_cyc - m_wstart == DT) begin
                            m_err = 1; m_mode = 0;
                        end
                    end
                endcase
                m_req  = (m_mode == 2) && (m_cyc > m_pstart)
                         && (m_cyc <= m_pstart + P);
                m_busy = (m_mode != 1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge pll_clk);
            if (cmp_on) begin
                chk("req",   int'(o_rst_req),   int'(m_req));
                chk("cause", int'(o_rst_cause), int'(m_cause));
                chk("err",   int'(o_drop_err),  int'(m_err));
                chk("busy",  int'(o_busy),      int'(m_busy));
            end
        end
    end

    task automatic catch_pulse(input bit drop, output int rise,
                               output int len, output int dcyc);
        rise = -1; len = 0; dcyc = cyc;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (o_rst_req) begin
                rise = cyc;
                break;
            end
        end
        if (rise < 0) begin
            chk("pulse_timeout", 0, 1);
        end else begin
            len = 1;
            for (int k = 1; k < 60; k++) begin
                tick(1);
                if (drop && k == 3) begin
                    i_sys_ready = 1'b0;
                    dcyc = cyc;
                end
                if (o_rst_req) len++;
            end
        end
    endtask

    initial begin : main
        int s, rise, len, dcyc, n, errc, fall;

        #1 i_brd_rst = 1'b1;
        #1 cmp_on = 1'b1;
        tick(5);
        chk("rst_req",   int'(o_rst_req),   0);
        chk("rst_cause", int'(o_rst_cause), 0);
        chk("rst_err",   int'(o_drop_err),  0);
        chk("rst_busy",  int'(o_busy),      1);
        i_brd_rst = 1'b0;
        while (cyc < 20) tick(1);
        i_sys_ready = 1'b1;
        @(negedge pll_clk);
        chk("busy_before_ready", int'(o_busy), 1);
        tick(1);
        chk("busy_after_ready", int'(o_busy), 0);
        n = 0;
        repeat (1000) begin
            tick(1);
            if (o_rst_req) n++;
        end
        chk("idle_no_req", n, 0);

        // Soft request with ready dropping inside the pulse.
        i_soft_req = 1'b1; s = cyc;
        tick(2);
        i_soft_req = 1'b0;
        catch_pulse(1'b1, rise, len, dcyc);
        chk("soft_start", rise - s, 4);
        chk("soft_len", len, P);
        chk("soft_cause", int'(o_rst_cause), 1);
        tick(200 - (cyc - dcyc) - 1);
        chk("soft_busy_low_ready", int'(o_busy), 1);
        i_sys_ready = 1'b1;
        tick(1);
        chk("soft_rearm", int'(o_busy), 0);
        chk("soft_cause_kept", int'(o_rst_cause), 1);

        // Watchdog expiry, no kicks.
        i_wdt_en = 1'b1; s = cyc;
        catch_pulse(1'b1, rise, len, dcyc);
        chk("wdt_start", rise - s, WL + 3);
        chk("wdt_len", len, P);
        chk("wdt_cause", int'(o_rst_cause), 2);
        i_wdt_en = 1'b0;
        tick(4);
        i_sys_ready = 1'b1;
        tick(3);
        chk("wdt_rearm", int'(o_busy), 0);

        // Periodic kicks keep the watchdog quiet.
        i_wdt_en = 1'b1; n = 0;
        for (int i = 0; i < 10000; i++) begin
            i_wdt_kick = ((i % 50) < 2);
            tick(1);
            if (o_rst_req) n++;
        end
        i_wdt_kick = 1'b0; i_wdt_en = 1'b0;
        chk("kick_no_req", n, 0);
        tick(5);

        // Soft edge on the expiry cycle.
        i_wdt_en = 1'b1; s = cyc;
        tick(WL - 1);
        i_soft_req = 1'b1;
        tick(2);
        i_soft_req = 1'b0;
        catch_pulse(1'b1, rise, len, dcyc);
        chk("simul_soft_start", rise - s, WL + 3);
        chk("simul_soft_len", len, P);
        chk("simul_soft_cause", int'(o_rst_cause), 1);
        i_wdt_en = 1'b0;
        tick(4);
        i_sys_ready = 1'b1;
        tick(3);

        // Kick on the expiry cycle.
        i_wdt_en = 1'b1; s = cyc;
        tick(WL - 1);
        i_wdt_kick = 1'b1;
        tick(2);
        i_wdt_kick = 1'b0;
        n = 0;
        repeat (60) begin
            tick(1);
            if (o_rst_req) n++;
        end
        i_wdt_en = 1'b0;
        chk("simul_kick_no_req", n, 0);
        tick(5);

        // Ready held high through a request.
        i_soft_req = 1'b1;
        tick(2);
        i_soft_req = 1'b0;
        catch_pulse(1'b0, rise, len, dcyc);
        chk("hold_len", len, P);
        fall = rise + P;
        errc = -1;
        for (int k = 0; k < 400; k++) begin
            if (o_drop_err) begin
                errc = cyc;
                break;
            end
            tick(1);
        end
        chk("drop_err_delay", errc - fall, DT);
        chk("drop_err_busy", int'(o_busy), 1);
        tick(1);
        chk("drop_err_rearm", int'(o_busy), 0);

        // Board reset in the middle of a pulse.
        i_soft_req = 1'b1;
        tick(2);
        i_soft_req = 1'b0;
        rise = -1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (o_rst_req) begin
                rise = cyc;
                break;
            end
        end
        chk("mid_pulse_seen", int'(rise > 0), 1);
        tick(7);
        chk("mid_pulse_high", int'(o_rst_req), 1);
        i_brd_rst = 1'b1;
        #1;
        chk("mid_rst_req",   int'(o_rst_req),   0);
        chk("mid_rst_cause", int'(o_rst_cause), 0);
        chk("mid_rst_err",   int'(o_drop_err),  0);
        chk("mid_rst_busy",  int'(o_busy),      1);
        tick(2);
        i_brd_rst = 1'b0;
        tick(3);

        // Random traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 99) < 4) i_soft_req = ~i_soft_req;
            i_wdt_kick = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 299) == 0) i_wdt_en = ~i_wdt_en;
            if (i_sys_ready) begin
                if ($urandom_range(0, 299) == 0) i_sys_ready = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                i_sys_ready = 1'b1;
            end
            if (i_brd_rst) i_brd_rst = 1'b0;
            else if ($urandom_range(0, 4999) == 0) i_brd_rst = 1'b1;
            tick(1);
        end
        i_brd_rst = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
